// File: rtl/dmem_mmio_bridge.sv
// CPU data-port bridge: passes loads/stores through to data_memory and decodes a 256-byte
// MMIO window (console TX FIFO, TOHOST halt register, cycle counter under MMIO_CYCLE_COUNTER_EN).
module dmem_mmio_bridge #(
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [3:0]  cpu_byte_en,
    output logic [31:0] cpu_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        halted,
    output logic [31:0] exit_code
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [5:0] IDX_TXDATA   = 6'd0;
    localparam logic [5:0] IDX_STATUS   = 6'd1;
    localparam logic [5:0] IDX_TOHOST   = 6'd2;
    localparam logic [5:0] IDX_CYCLE_LO = 6'd3;
    localparam logic [5:0] IDX_CYCLE_HI = 6'd4;

    logic        sel;
    logic [5:0]  reg_idx;
    logic [31:0] mmio_rdata;
    logic [31:0] status_word;

    logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          halted_reg;
    logic [31:0]   exit_code_reg, exit_code_next;

    logic fifo_empty, fifo_full;
    logic push_req, push_ok, pop;
    logic status_wr, tohost_wr;

    assign sel     = (cpu_addr[31:8] == MMIO_BASE[31:8]);
    assign reg_idx = cpu_addr[7:2];

    // Address, data and lanes always mirror the CPU; only the strobes are gated by the decode.
    assign mem_addr    = cpu_addr;
    assign mem_wdata   = cpu_wdata;
    assign mem_byte_en = cpu_byte_en;
    assign mem_we      = cpu_we & ~sel;
    assign mem_re      = cpu_re & ~sel;
    assign cpu_rdata   = sel ? mmio_rdata : mem_rdata;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign con_valid  = ~fifo_empty;
    assign con_data   = fifo_mem[rd_ptr_reg];
    assign halted     = halted_reg;
    assign exit_code  = exit_code_reg;

    assign pop       = con_valid & con_ready;
    assign push_req  = sel & cpu_we & (reg_idx == IDX_TXDATA) & cpu_byte_en[0];
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok   = push_req & (~fifo_full | pop);
    assign status_wr = sel & cpu_we & (reg_idx == IDX_STATUS);
    assign tohost_wr = sel & cpu_we & (reg_idx == IDX_TOHOST) & (cpu_byte_en != 4'b0000);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_exit_lane
            assign exit_code_next[8*gi +: 8] = cpu_byte_en[gi] ? cpu_wdata[8*gi +: 8]
                                                               : exit_code_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (pop)
            rd_ptr_next = rd_ptr_reg + 1'b1;
        if (push_ok)
            wr_ptr_next = wr_ptr_reg + 1'b1;
        if (push_ok && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !push_ok)
            count_next = count_reg - 1'b1;
        if (push_req && !push_ok)
            overflow_next = 1'b1;
        else if (status_wr)
            overflow_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            halted_reg    <= 1'b0;
            exit_code_reg <= '0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            if (tohost_wr) begin
                halted_reg    <= 1'b1;
                exit_code_reg <= exit_code_next;
            end
        end
    end

    // Storage is left uninitialised on reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= cpu_wdata[7:0];
    end

    assign status_word = {16'h0000, {(8 - CW){1'b0}}, count_reg,
                          4'h0, halted_reg, overflow_reg, fifo_empty, fifo_full};

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [63:0] cycle_reg;

    always_ff @(posedge clk) begin
        if (rst)
            cycle_reg <= '0;
        else if (!halted_reg)
            cycle_reg <= cycle_reg + 64'd1;
    end

    always_comb begin
        mmio_rdata = '0;
        case (reg_idx)
            IDX_STATUS:   mmio_rdata = status_word;
            IDX_TOHOST:   mmio_rdata = exit_code_reg;
            IDX_CYCLE_LO: mmio_rdata = cycle_reg[31:0];
            IDX_CYCLE_HI: mmio_rdata = cycle_reg[63:32];
            default:      mmio_rdata = '0;
        endcase
    end
`else
    always_comb begin
        mmio_rdata = '0;
        case (reg_idx)
            IDX_STATUS: mmio_rdata = status_word;
            IDX_TOHOST: mmio_rdata = exit_code_reg;
            default:    mmio_rdata = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed self-checking bench for dmem_mmio_bridge with a small behavioural data_memory.
module tb_dmem_mmio_bridge;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [3:0]  cpu_byte_en = '0;
    logic [31:0] cpu_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;
    logic        halted;
    logic [31:0] exit_code;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] tb_mem [0:15];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we && mem_byte_en[b])
                tb_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    assign mem_rdata = tb_mem[mem_addr[5:2]];

    dmem_mmio_bridge dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_byte_en(cpu_byte_en), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata),
        .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
        .halted(halted), .exit_code(exit_code)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mmio_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] be);
        cpu_addr = BASE | {24'h0, off};
        cpu_wdata = data;
        cpu_byte_en = be;
        cpu_we = 1'b1;
        cycle();
        cpu_we = 1'b0;
        cpu_byte_en = 4'h0;
    endtask

    task automatic mmio_read(input logic [7:0] off, output logic [31:0] data);
        cpu_addr = BASE | {24'h0, off};
        cpu_re = 1'b1;
        #1;
        data = cpu_rdata;
        cpu_re = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        total_cnt++;
        if (con_valid !== 1'b0) $display("FAIL reset_con_valid got=%b exp=0", con_valid);
        else pass_cnt++;
        total_cnt++;
        if (halted !== 1'b0 || exit_code !== 32'h0)
            $display("FAIL reset_halt got halted=%b exit=%h exp 0/0", halted, exit_code);
        else pass_cnt++;
        mmio_read(8'h04, d);
        total_cnt++;
        if (d !== 32'h0000_0002) $display("FAIL reset_status got=%h exp=00000002", d);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_passthrough();
        logic [31:0] d;
        cpu_addr = 32'h0000_0010;
        cpu_wdata = 32'hDEAD_BEEF;
        cpu_byte_en = 4'hF;
        cpu_we = 1'b1;
        #1;
        total_cnt++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF || mem_byte_en !== 4'hF)
            $display("FAIL pass_store got we=%b addr=%h wd=%h be=%h exp 1/00000010/deadbeef/f",
                     mem_we, mem_addr, mem_wdata, mem_byte_en);
        else pass_cnt++;
        cycle();
        cpu_we = 1'b0;
        cpu_byte_en = 4'h0;
        #1;
        total_cnt++;
        if (mem_we !== 1'b0) $display("FAIL pass_we_pulse got=%b exp=0", mem_we);
        else pass_cnt++;
        cpu_re = 1'b1;
        #1;
        total_cnt++;
        if (mem_re !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF)
            $display("FAIL pass_load got re=%b rdata=%h exp 1/deadbeef", mem_re, cpu_rdata);
        else pass_cnt++;
        cpu_re = 1'b0;
        // lane 0 off, so no console push happens
        cpu_addr = BASE;
        cpu_wdata = 32'h1234_5678;
        cpu_byte_en = 4'hE;
        cpu_we = 1'b1;
        #1;
        total_cnt++;
        if (mem_we !== 1'b0 || mem_addr !== BASE)
            $display("FAIL hit_store_we got we=%b addr=%h exp 0/ffff0000", mem_we, mem_addr);
        else pass_cnt++;
        cycle();
        cpu_we = 1'b0;
        cpu_byte_en = 4'h0;
        cpu_addr = BASE | 32'h14;
        cpu_re = 1'b1;
        #1;
        total_cnt++;
        if (mem_re !== 1'b0 || cpu_rdata !== 32'h0)
            $display("FAIL hit_unmapped_read got re=%b rdata=%h exp 0/00000000", mem_re, cpu_rdata);
        else pass_cnt++;
        cpu_re = 1'b0;
        mmio_read(8'h00, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL txdata_read got=%h exp=00000000", d);
        else pass_cnt++;
        mmio_read(8'h04, d);
        total_cnt++;
        if (d !== 32'h0000_0002) $display("FAIL pass_status got=%h exp=00000002", d);
        else pass_cnt++;
        $display("test_passthrough done");
    endtask

    task automatic test_console_order();
        logic [31:0] d;
        con_ready = 1'b0;
        mmio_write(8'h00, 32'hFFFF_FF48, 4'h1);
        mmio_write(8'h00, 32'h0000_0069, 4'h1);
        mmio_read(8'h04, d);
        total_cnt++;
        if (d !== 32'h0000_0200) $display("FAIL console_status got=%h exp=00000200", d);
        else pass_cnt++;
        con_ready = 1'b1;
        #1;
        total_cnt++;
        if (con_valid !== 1'b1 || con_data !== 8'h48)
            $display("FAIL console_byte0 got v=%b d=%h exp 1/48", con_valid, con_data);
        else pass_cnt++;
        cycle();
        total_cnt++;
        if (con_valid !== 1'b1 || con_data !== 8'h69)
            $display("FAIL console_byte1 got v=%b d=%h exp 1/69", con_valid, con_data);
        else pass_cnt++;
        cycle();
        con_ready = 1'b0;
        total_cnt++;
        if (con_valid !== 1'b0) $display("FAIL console_drained got=%b exp=0", con_valid);
        else pass_cnt++;
        mmio_read(8'h04, d);
        total_cnt++;
        if (d !== 32'h0000_0002) $display("FAIL console_status_empty got=%h exp=00000002", d);
        else pass_cnt++;
        $display("test_console_order done");
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        con_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            mmio_write(8'h00, i, 4'h1);
        mmio_read(8'h04, d);
        total_cnt++;
        if (d !== 32'h0000_0805) $display("FAIL overflow_status got=%h exp=00000805", d);
        else pass_cnt++;
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            total_cnt++;
            if (con_valid !== 1'b1 || con_data !== i[7:0])
                $display("FAIL overflow_drain_%0d got v=%b d=%h exp 1/%h", i, con_valid, con_data, i[7:0]);
            else pass_cnt++;
            cycle();
        end
        con_ready = 1'b0;
        total_cnt++;
        if (con_valid !== 1'b0) $display("FAIL overflow_extra_byte got v=%b exp=0", con_valid);
        else pass_cnt++;
        mmio_read(8'h04, d);
        total_cnt++;
        if (d !== 32'h0000_0006) $display("FAIL overflow_sticky got=%h exp=00000006", d);
        else pass_cnt++;
        mmio_write(8'h04, 32'h0, 4'hF);
        mmio_read(8'h04, d);
        total_cnt++;
        if (d !== 32'h0000_0002) $display("FAIL overflow_clear got=%h exp=00000002", d);
        else pass_cnt++;
        $display("test_overflow done");
    endtask

    task automatic test_full_pop();
        logic [31:0] d;
        logic [7:0]  exp_b;
        con_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            mmio_write(8'h00, 32'h10 + i, 4'h1);
        mmio_read(8'h04, d);
        total_cnt++;
        if (d !== 32'h0000_0801) $display("FAIL full_status got=%h exp=00000801", d);
        else pass_cnt++;
        con_ready = 1'b1;
        mmio_write(8'h00, 32'hAA, 4'h1);
        con_ready = 1'b0;
        mmio_read(8'h04, d);
        total_cnt++;
        if (d !== 32'h0000_0801) $display("FAIL full_pop_status got=%h exp=00000801", d);
        else pass_cnt++;
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_b = (i == 7) ? 8'hAA : 8'(8'h11 + i);
            #1;
            total_cnt++;
            if (con_valid !== 1'b1 || con_data !== exp_b)
                $display("FAIL full_pop_drain_%0d got v=%b d=%h exp 1/%h", i, con_valid, con_data, exp_b);
            else pass_cnt++;
            cycle();
        end
        con_ready = 1'b0;
        total_cnt++;
        if (con_valid !== 1'b0) $display("FAIL full_pop_empty got=%b exp=0", con_valid);
        else pass_cnt++;
        $display("test_full_pop done");
    endtask

    task automatic test_halt();
        logic [31:0] d, c1, c2;
        mmio_read(8'h0C, c1);
        cycle();
        cycle();
        cycle();
        mmio_read(8'h0C, c2);
`ifdef MMIO_CYCLE_COUNTER_EN
        total_cnt++;
        if (c2 - c1 !== 32'd3) $display("FAIL cycle_running got delta=%0d exp=3", c2 - c1);
        else pass_cnt++;
`else
        total_cnt++;
        if (c1 !== 32'h0 || c2 !== 32'h0) $display("FAIL cycle_absent got=%h/%h exp=0/0", c1, c2);
        else pass_cnt++;
`endif
        mmio_write(8'h08, 32'h0000_0001, 4'hF);
        total_cnt++;
        if (halted !== 1'b1 || exit_code !== 32'h1)
            $display("FAIL halt_set got halted=%b exit=%h exp 1/00000001", halted, exit_code);
        else pass_cnt++;
        mmio_read(8'h04, d);
        total_cnt++;
        if (d !== 32'h0000_000A) $display("FAIL halt_status got=%h exp=0000000a", d);
        else pass_cnt++;
        mmio_read(8'h0C, c1);
        for (int i = 0; i < 5; i++) cycle();
        mmio_read(8'h0C, c2);
`ifdef MMIO_CYCLE_COUNTER_EN
        total_cnt++;
        if (c1 !== c2 || c1 === 32'h0) $display("FAIL cycle_frozen got=%h/%h exp equal nonzero", c1, c2);
        else pass_cnt++;
`else
        total_cnt++;
        if (c1 !== 32'h0 || c2 !== 32'h0) $display("FAIL cycle_lo_zero got=%h/%h exp=0/0", c1, c2);
        else pass_cnt++;
`endif
        mmio_write(8'h08, 32'hAABB_CCDD, 4'b0101);
        mmio_read(8'h08, d);
        total_cnt++;
        if (d !== 32'h00BB_00DD || exit_code !== 32'h00BB_00DD)
            $display("FAIL tohost_lanes got rd=%h exit=%h exp=00bb00dd", d, exit_code);
        else pass_cnt++;
        mmio_write(8'h00, 32'h55, 4'h1);
        total_cnt++;
        if (con_valid !== 1'b1 || con_data !== 8'h55)
            $display("FAIL push_after_halt got v=%b d=%h exp 1/55", con_valid, con_data);
        else pass_cnt++;
        $display("test_halt done");
    endtask

    task automatic test_reset_midstream();
        logic [31:0] d;
        mmio_write(8'h00, 32'h56, 4'h1);
        mmio_write(8'h00, 32'h57, 4'h1);
        mmio_read(8'h04, d);
        total_cnt++;
        if (d[15:8] !== 8'd3) $display("FAIL midstream_count got=%0d exp=3", d[15:8]);
        else pass_cnt++;
        rst = 1'b1;
        cpu_addr = 32'h0000_0004;
        cpu_we = 1'b1;
        cpu_byte_en = 4'hF;
        #1;
        total_cnt++;
        if (mem_we !== 1'b1) $display("FAIL reset_passthrough got we=%b exp=1", mem_we);
        else pass_cnt++;
        cycle();
        cpu_we = 1'b0;
        cpu_byte_en = 4'h0;
        rst = 1'b0;
        total_cnt++;
        if (con_valid !== 1'b0 || halted !== 1'b0 || exit_code !== 32'h0)
            $display("FAIL midstream_reset got v=%b halted=%b exit=%h exp 0/0/0", con_valid, halted, exit_code);
        else pass_cnt++;
        mmio_read(8'h04, d);
        total_cnt++;
        if (d !== 32'h0000_0002) $display("FAIL midstream_status got=%h exp=00000002", d);
        else pass_cnt++;
`ifdef MMIO_CYCLE_COUNTER_EN
        mmio_read(8'h10, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL cycle_hi_reset got=%h exp=00000000", d);
        else pass_cnt++;
`endif
        $display("test_reset_midstream done");
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_console_order();
        test_overflow();
        test_full_pop();
        test_halt();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
